// File: rtl/raccoon_move_sched_pkg.sv
// raccoon_move_sched_pkg: shared directions, states, playfield/sprite geometry and hop bounds check
package raccoon_move_sched_pkg;
  localparam int c_SPRITE_W = 32;
  localparam int c_SPRITE_H = 32;
  localparam int c_GAME_WIDTH = 640;
  localparam int c_GAME_HEIGHT = 480;
  localparam int c_STEP = 32;
  localparam logic [9:0] c_HOME_X = 10'((c_GAME_WIDTH - c_SPRITE_W) / 2);
  localparam logic [9:0] c_HOME_Y = 10'(c_GAME_HEIGHT - c_SPRITE_H);
  typedef enum logic [1:0] {DIR_UP, DIR_DN, DIR_LT, DIR_RT} dir_e;
  typedef enum logic [2:0] {ST_IDLE, ST_HOLD, ST_REPEAT, ST_FROZEN, ST_WAIT_REL} state_e;
  // 11-bit sums so a hop near the far edge cannot wrap and look legal
  function automatic logic hop_ok(input dir_e d, input logic [9:0] x, input logic [9:0] y);
    logic [10:0] xs, ys;
    xs = {1'b0, x} + 11'(c_STEP);
    ys = {1'b0, y} + 11'(c_STEP);
    return d == DIR_UP ? ({1'b0, y} >= 11'(c_STEP)) :
           d == DIR_DN ? (ys <= 11'(c_GAME_HEIGHT - c_SPRITE_H)) :
           d == DIR_LT ? ({1'b0, x} >= 11'(c_STEP)) :
                         (xs <= 11'(c_GAME_WIDTH - c_SPRITE_W));
  endfunction
endpackage

// File: rtl/raccoon_dir_arbiter.sv
// raccoon_dir_arbiter: combinational 4-way direction grant
// Ports: i_Req {Rt,Lt,Dn,Up} button levels, i_Last last grant (round-robin only), o_Gnt granted direction.
// RACCOON_MOVE_ROUND_ROBIN_EN selects round-robin from i_Last+1; otherwise fixed Up > Dn > Lt > Rt.
module raccoon_dir_arbiter
  import raccoon_move_sched_pkg::*;
(
  input  logic [3:0] i_Req,
`ifdef RACCOON_MOVE_ROUND_ROBIN_EN
  input  dir_e       i_Last,
`endif
  output dir_e       o_Gnt
);
  always_comb begin
    o_Gnt = DIR_UP;
`ifdef RACCOON_MOVE_ROUND_ROBIN_EN
    for (int i = 3; i >= 0; i--)
      if (i_Req[2'(i_Last + 2'(i) + 2'd1)]) o_Gnt = dir_e'(2'(i_Last + 2'(i) + 2'd1));
`else
    for (int i = 3; i >= 0; i--)
      if (i_Req[i]) o_Gnt = dir_e'(2'(i));
`endif
  end
endmodule

// File: rtl/raccoon_move_sched.sv
// raccoon_move_sched: raccoon sprite movement scheduler with hold-to-repeat, bounds, freeze and respawn
// Ports: i_Clk, i_Rst_n (async active-low), i_Up/i_Dn/i_Lt/i_Rt buttons, i_Freeze, i_Respawn pulse;
// o_Pos_X/o_Pos_Y sprite top-left, o_Move_Pulse hop accepted, o_Dir last grant, o_Blocked hop refused.
// RACCOON_MOVE_ROUND_ROBIN_EN switches the arbiter to round-robin.
module raccoon_move_sched
  import raccoon_move_sched_pkg::*;
#(
  parameter int unsigned c_REPEAT_DELAY  = 12500000,
  parameter int unsigned c_REPEAT_PERIOD = 2550000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Up,
  input  logic       i_Dn,
  input  logic       i_Lt,
  input  logic       i_Rt,
  input  logic       i_Freeze,
  input  logic       i_Respawn,
  output logic [9:0] o_Pos_X,
  output logic [9:0] o_Pos_Y,
  output logic       o_Move_Pulse,
  output logic [1:0] o_Dir,
  output logic       o_Blocked
);
  logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [23:0] cnt_q, cnt_d;
  logic mv_q, mv_d, blk_q, blk_d, hop_en;
  logic [3:0] req;
  dir_e dir_q, dir_d, gnt, hop_dir;
  state_e state_q, state_d;
  assign req = {i_Rt, i_Lt, i_Dn, i_Up};
  raccoon_dir_arbiter u_arb (
    .i_Req  (req),
`ifdef RACCOON_MOVE_ROUND_ROBIN_EN
    .i_Last (dir_q),
`endif
    .o_Gnt  (gnt)
  );
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    mv_d = 1'b0;
    blk_d = 1'b0;
    hop_en = 1'b0;
    hop_dir = state_q == ST_IDLE ? gnt : dir_q;
    if (i_Respawn) begin
      pos_x_d = c_HOME_X;
      pos_y_d = c_HOME_Y;
      cnt_d = '0;
      state_d = i_Freeze ? ST_FROZEN : ST_WAIT_REL;
    end else if (i_Freeze) begin
      cnt_d = '0;
      state_d = ST_FROZEN;
    end else begin
      case (state_q)
        ST_IDLE: if (|req) begin
          dir_d = gnt;
          hop_en = 1'b1;
          cnt_d = 24'(c_REPEAT_DELAY - 1);
          state_d = ST_HOLD;
        end
        ST_HOLD, ST_REPEAT: if (!req[dir_q]) state_d = ST_IDLE;
        else if (cnt_q == '0) begin
          hop_en = 1'b1;
          cnt_d = 24'(c_REPEAT_PERIOD - 1);
          state_d = ST_REPEAT;
        end else cnt_d = cnt_q - 1'b1;
        ST_FROZEN: state_d = ST_WAIT_REL;
        ST_WAIT_REL: if (req == '0) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    if (hop_en) begin
      mv_d = hop_ok(hop_dir, pos_x_q, pos_y_q);
      blk_d = !mv_d;
      if (mv_d) begin
        pos_x_d = hop_dir == DIR_LT ? pos_x_q - 10'(c_STEP) : hop_dir == DIR_RT ? pos_x_q + 10'(c_STEP) : pos_x_q;
        pos_y_d = hop_dir == DIR_UP ? pos_y_q - 10'(c_STEP) : hop_dir == DIR_DN ? pos_y_q + 10'(c_STEP) : pos_y_q;
      end
    end
  end
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      dir_q <= DIR_UP;
      cnt_q <= '0;
      pos_x_q <= c_HOME_X;
      pos_y_q <= c_HOME_Y;
      mv_q <= 1'b0;
      blk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      mv_q <= mv_d;
      blk_q <= blk_d;
    end
  end
  assign o_Pos_X = pos_x_q;
  assign o_Pos_Y = pos_y_q;
  assign o_Move_Pulse = mv_q;
  assign o_Blocked = blk_q;
  assign o_Dir = dir_q;
endmodule

// File: tb/tb_raccoon_move_sched.sv
// tb_raccoon_move_sched: directed self-checking bench for raccoon_move_sched (repeat delay 4, period 2)
module tb_raccoon_move_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  logic up = 1'b0, dn = 1'b0, lt = 1'b0, rt = 1'b0, frz = 1'b0, rsp = 1'b0;
  logic [9:0] px, py;
  logic mv, blk;
  logic [1:0] dir;
  int checks = 0, errors = 0;
  int m, b, x0;
`ifdef RACCOON_MOVE_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  always #5 clk = ~clk;
  raccoon_move_sched #(.c_REPEAT_DELAY(4), .c_REPEAT_PERIOD(2)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Up(up), .i_Dn(dn), .i_Lt(lt), .i_Rt(rt),
    .i_Freeze(frz), .i_Respawn(rsp), .o_Pos_X(px), .o_Pos_Y(py),
    .o_Move_Pulse(mv), .o_Dir(dir), .o_Blocked(blk)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic run(input int n, output int mvm, output int blkm);
    mvm = 0;
    blkm = 0;
    for (int c = 0; c < n; c++) begin
      step(1);
      if (mv) mvm |= 1 << c;
      if (blk) blkm |= 1 << c;
    end
  endtask
  initial begin
    step(2);
    chk("rst_x", px, 304);
    chk("rst_y", py, 448);
    chk("rst_mv", mv, 0);
    chk("rst_blk", blk, 0);
    chk("rst_dir", dir, 0);
    rst_n = 1'b1;
    step(1);
    rt = 1'b1;
    step(1);
    chk("a_mv", mv, 1);
    chk("a_x", px, 336);
    step(1);
    rst_n = 1'b0;
    #1;
    chk("a_async_x", px, 304);
    rt = 1'b0;
    step(1);
    rst_n = 1'b1;
    run(3, m, b);
    chk("a_pulses", m | b, 0);
    chk("a_x2", px, 304);
    chk("a_y2", py, 448);
    dn = 1'b1;
    run(6, m, b);
    chk("b_blk", b, 'h11);
    chk("b_mv", m, 0);
    chk("b_y", py, 448);
    chk("b_dir", dir, 1);
    dn = 1'b0;
    step(1);
    up = 1'b1;
    step(1);
    chk("c_mv", mv, 1);
    chk("c_y", py, 416);
    chk("c_dir", dir, 0);
    up = 1'b0;
    step(1);
    chk("c_idle_mv", mv, 0);
    chk("c_y2", py, 416);
    rt = 1'b1;
    run(10, m, b);
    chk("d_hops", m, 'h151);
    chk("d_x", px, 432);
    chk("d_dir", dir, 3);
    rt = 1'b0;
    step(1);
    up = 1'b1;
    lt = 1'b1;
    run(4, m, b);
    chk("e1_hops", m, 1);
    chk("e1_dir", dir, 0);
    chk("e1_x", px, 432);
    chk("e1_y", py, 384);
    up = 1'b0;
    lt = 1'b0;
    step(1);
    up = 1'b1;
    lt = 1'b1;
    step(1);
    chk("e2_dir", dir, RR ? 2 : 0);
    chk("e2_x", px, RR ? 400 : 432);
    chk("e2_y", py, RR ? 384 : 352);
    up = 1'b0;
    lt = 1'b0;
    step(1);
    up = 1'b1;
    lt = 1'b1;
    step(1);
    chk("e3_y", py, RR ? 352 : 320);
    up = 1'b0;
    step(1);
    chk("e3_rel_mv", mv, 0);
    step(1);
    chk("e3_lt_mv", mv, 1);
    chk("e3_dir", dir, 2);
    chk("e3_x", px, RR ? 368 : 400);
    lt = 1'b0;
    step(1);
    x0 = RR ? 368 : 400;
    rt = 1'b1;
    step(1);
    chk("f_mv", mv, 1);
    chk("f_x", px, x0 + 32);
    frz = 1'b1;
    run(4, m, b);
    chk("f_frozen", m | b, 0);
    frz = 1'b0;
    run(6, m, b);
    chk("f_wait", m | b, 0);
    chk("f_x2", px, x0 + 32);
    rt = 1'b0;
    step(1);
    rt = 1'b1;
    run(5, m, b);
    chk("f_rep", m, 'h11);
    chk("f_x3", px, x0 + 96);
    rsp = 1'b1;
    step(1);
    rsp = 1'b0;
    chk("g_x", px, 304);
    chk("g_y", py, 448);
    chk("g_mv", mv, 0);
    run(6, m, b);
    chk("g_hold", m | b, 0);
    rt = 1'b0;
    step(1);
    rt = 1'b1;
    step(1);
    chk("g_new_mv", mv, 1);
    chk("g_x2", px, 336);
    rt = 1'b0;
    step(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1);
  end
endmodule

// File: doc/raccoon_move_sched.md
Name: raccoon_move_sched

Overview:
- Movement scheduler for the raccoon player sprite; owns the sprite's X/Y grid position.
- Arbitrates the four direction buttons and issues one grid hop per press, with hold-to-repeat after an initial delay.
- Enforces playfield bounds and obeys freeze/respawn commands from the game-state logic.
- Its position outputs drive the sprite draw logic and the collision checker.

Parameters:
- c_SPRITE_W, 32, sprite width in pixels
- c_SPRITE_H, 32, sprite height in pixels
- c_GAME_WIDTH, 640, playfield width
- c_GAME_HEIGHT, 480, playfield height
- c_STEP, 32, hop size in pixels, applied to both axes
- c_REPEAT_DELAY, 12500000, clocks a button must be held before the first repeat hop
- c_REPEAT_PERIOD, 2550000, clocks between repeat hops

Ports:
- i_Clk  in  1  system clock
- i_Rst_n  in  1  asynchronous active-low reset
- i_Up / i_Dn / i_Lt / i_Rt  in  1 each  debounced button levels
- i_Freeze  in  1  game paused/over; inhibits all moves
- i_Respawn  in  1  single-cycle pulse; returns sprite to home position
- o_Pos_X  out  10  sprite left edge
- o_Pos_Y  out  10  sprite top edge
- o_Move_Pulse  out  1  one-cycle pulse on each accepted hop
- o_Dir  out  2  direction of last grant (0=Up, 1=Dn, 2=Lt, 3=Rt)
- o_Blocked  out  1  one-cycle pulse when a hop is refused at a boundary

Behaviour:
- Reset (async assert, sync release):
  - o_Pos_X = (c_GAME_WIDTH-c_SPRITE_W)/2 = 304; o_Pos_Y = c_GAME_HEIGHT-c_SPRITE_H = 448 (home).
  - o_Move_Pulse = 0, o_Blocked = 0, o_Dir = 0, counter = 0, state = IDLE.
- States:
  - IDLE: if i_Freeze, go to FROZEN. Otherwise, if any button is high, arbitrate, latch the grant into o_Dir, attempt a hop on the same edge, load counter = c_REPEAT_DELAY-1 and go to HOLD.
  - HOLD: if the granted button is low, go to IDLE. Otherwise decrement the counter; at 0, attempt a hop, load c_REPEAT_PERIOD-1 and go to REPEAT.
  - REPEAT: identical to HOLD, but reloads c_REPEAT_PERIOD-1 after each hop.
  - FROZEN: no hops; counter held at 0. Go to WAIT_REL when i_Freeze is low.
  - WAIT_REL: go to IDLE only once all four buttons are low, so a held button cannot produce a hop on unfreeze.
- Granted-button rule: while in HOLD/REPEAT, non-granted buttons are ignored; only release of the granted button returns to IDLE.
- i_Freeze in any state moves to FROZEN on the next edge, aborting any pending repeat.
- Hop attempt: compute the target using 11-bit arithmetic to avoid wrap.
  - Up: accepted if Y >= c_STEP. Dn: accepted if Y+c_STEP <= c_GAME_HEIGHT-c_SPRITE_H.
  - Lt: accepted if X >= c_STEP. Rt: accepted if X+c_STEP <= c_GAME_WIDTH-c_SPRITE_W.
  - Accepted: position updates and o_Move_Pulse=1 on that edge.
  - Refused: position unchanged, o_Blocked=1 on that edge; the state machine still advances normally (repeat timing continues).
- Latency: a button first sampled high in IDLE updates position on that same edge; the new value is visible the following cycle.
- i_Respawn has priority over everything except reset: position returns to home, pulses are cleared, counter = 0, state = WAIT_REL (or FROZEN if i_Freeze is high).
- o_Move_Pulse and o_Blocked are never both high, and neither asserts outside IDLE/HOLD/REPEAT.

Optional Feature:
- Macro: RACCOON_MOVE_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. The search starts at the direction after the last grant (o_Dir+1 mod 4), so simultaneous presses rotate grants.
- Undefined: fixed priority Up > Dn > Lt > Rt.

Decomposition:
- Shared package: direction encodings (DIR_UP/DN/LT/RT), state encodings, c_STEP and playfield/sprite size constants shared with the draw and collision logic.
- One sub-module: raccoon_dir_arbiter — combinational 4-way grant with an optional last-grant pointer input (used only under RACCOON_MOVE_ROUND_ROBIN_EN).

Test Plan (bench uses c_REPEAT_DELAY=4, c_REPEAT_PERIOD=2):
- Reset mid-run, then release -> Pos=(304,448); no pulses.
- i_Up held 1 cycle -> one o_Move_Pulse; Y=416; o_Dir=0; back to IDLE.
- i_Rt held 10 cycles from X=304 -> hops at cycle 0, 4, 6, 8; X=432.
- i_Dn at Y=448 -> o_Blocked pulse, Y stays 448; held for 6 cycles gives further o_Blocked pulses on the repeat schedule.
- Up+Lt pressed together -> fixed priority: Up granted, Lt ignored until Up released. Under the macro: a second simultaneous press grants Lt.
- Freeze while holding Rt, then unfreeze with Rt still held -> no hops until Rt released and re-pressed. Respawn during REPEAT -> Pos=(304,448), no further hops until all buttons released.
